multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle FSM sequencer for the RV32I-subset core: one shared ALU, one unified memory, IR/OldPC/A/B/ALUOut/MDR regs.
//  Steps each instruction through fetch/decode/execute/writeback and drives every datapath select and write enable.
//  opc/f3/f7 come from the IR (stable from DECODE on). zero/sign come from the live ALU result.
//  mem_ready from memory stretches FETCH/MEMREAD/MEMWRITE.
// PARAMETERS
//  TRAP_ON_ILLEGAL  1  1: undecoded opcode -> sticky TRAP; 0: treated as NOP, return to FETCH
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  opc         in   7  IR[6:0]
//  f3          in   3  IR[14:12]
//  f7          in   7  IR[31:25]
//  zero        in   1  ALU result == 0
//  sign        in   1  ALU result[31]
//  mem_ready   in   1  memory access completes this cycle
//  PCWrite     out  1  load PC from Result
//  AdrSrc      out  1  mem addr: 0 PC, 1 ALUOut
//  MemW        out  1  memory write strobe
//  IRWrite     out  1  load IR and OldPC
//  RegW        out  1  register-file write
//  ResSrc      out  2  00 ALUOut, 01 MDR, 10 ALU result, 11 ImmExt
//  AluSrcA     out  2  00 PC, 01 OldPC, 10 A(rs1)
//  AluSrcB     out  2  00 B(rs2), 01 ImmExt, 10 const 4
//  AluCu       out  4  AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000
//  ImmSrc      out  3  I 000, S 001, B 010, J 011, U 100
//  done        out  1  1-cycle pulse in last cycle of each instruction
//  halted      out  1  1 while in TRAP
// BEHAVIOUR
//  Outputs combinational from state + inputs; unlisted outputs are 0, ResSrc/AluSrcA/AluSrcB/AluCu default 00/00/00/ADD.
//  ImmSrc decoded from opc in every state: LW/I/JALR->I, SW->S, B->B, JAL->J, LUI->U, other->I.
//  Reset: async to FETCH. While rst=1, all write enables, done and halted are 0.
//  FETCH: AdrSrc=0, SrcA=00, SrcB=10, ADD, ResSrc=10, IRWrite=PCWrite=mem_ready. Stays here until mem_ready, then DECODE.
//  DECODE: SrcA=01, SrcB=01, ADD (ALUOut<=OldPC+imm). Next state by opc:
//    LW/SW->MEMADR, R->EXEC_R, I->EXEC_I, JAL->JAL, JALR->JALR_ADR, B->BRANCH, LUI->LUI_WB, else->TRAP (or FETCH when TRAP_ON_ILLEGAL=0, done=1).
//  MEMADR: SrcA=10, SrcB=01, ADD. Next: LW->MEMREAD, SW->MEMWRITE.
//  MEMREAD: AdrSrc=1. Waits mem_ready, then MEMWB.
//  MEMWB: ResSrc=01, RegW=1, done=1. Next: FETCH.
//  MEMWRITE: AdrSrc=1, MemW=1 held until mem_ready; done=mem_ready. Then FETCH.
//  EXEC_R: SrcA=10, SrcB=00. AluCu from f7/f3:
//    f7=0000000: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU.
//    f7=0100000/000: SUB. Any other combination: ADD.
//    Next: ALUWB.
//  EXEC_I: SrcA=10, SrcB=01. AluCu from the f3 map above (f7 ignored, never SUB). Next: ALUWB.
//  ALUWB: ResSrc=00, RegW=1, done=1. Next: FETCH.
//  JALR_ADR: SrcA=10, SrcB=01, ADD (ALUOut<=rs1+imm). Next: JAL.
//  JAL: SrcA=01, SrcB=10, ADD, ResSrc=00, PCWrite=1 (PC<=ALUOut target, ALUOut<=OldPC+4). Next: ALUWB.
//  BRANCH: SrcA=10, SrcB=00, SUB, ResSrc=00, done=1. Next: FETCH.
//    PCWrite = beq(000): zero; bne(001): !zero; blt(100): sign; bge(101): !sign|zero; other f3: 0.
//  LUI_WB: ResSrc=11, RegW=1, done=1. Next: FETCH.
//  TRAP: halted=1, all enables 0; left only by rst.
//  Cycles at mem_ready=1: R/I/SW/JAL 4, LW/JALR 5, B/LUI 3. Each mem_ready=0 cycle adds 1.
//  rst mid-instruction aborts immediately; no partial write completes after rst rises.
//  A held mem_ready=1 in non-memory states has no effect.
// TESTING
//  add (opc 0110011, f3 000, f7 0) at mem_ready=1 -> FETCH,DECODE,EXEC_R(AluCu 0010),ALUWB(RegW=1, done=1); 4 cycles.
//  lw with mem_ready low 2 cycles in FETCH and in MEMREAD -> IRWrite only on the ready cycle; RegW in cycle 9; done once.
//  beq: zero=1 -> PCWrite=1 in BRANCH; bne with zero=1 -> PCWrite=0; bge with sign=0 -> taken; f3=010 -> never taken.
//  jalr -> JALR_ADR(SrcA 10, SrcB 01), JAL(PCWrite=1, ResSrc 00), ALUWB(RegW=1); 5 cycles.
//  opc 1111111 -> TRAP, halted=1, no enables for 20 cycles; rst -> FETCH, halted=0. Repeat with TRAP_ON_ILLEGAL=0 -> FETCH after DECODE, done=1.
//  rst asserted in MEMWRITE with MemW=1 -> MemW drops in the same cycle (async); after release starts in FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM sequencer for the RV32I-subset core: steps each instruction through
// fetch/decode/execute/writeback and drives all datapath selects and write enables.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemW,
    output logic       IRWrite,
    output logic       RegW,
    output logic [1:0] ResSrc,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [3:0] AluCu,
    output logic [2:0] ImmSrc,
    output logic       done,
    output logic       halted
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_JALR_ADR, S_JAL, S_BRANCH, S_LUI_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    state_t state_q, state_d;

    function automatic logic [3:0] f3_alu(input logic [2:0] f);
        case (f)
            3'b000:  return ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        PCWrite = 1'b0;
        AdrSrc  = 1'b0;
        MemW    = 1'b0;
        IRWrite = 1'b0;
        RegW    = 1'b0;
        ResSrc  = 2'b00;
        AluSrcA = 2'b00;
        AluSrcB = 2'b00;
        AluCu   = ALU_ADD;
        done    = 1'b0;
        halted  = 1'b0;

        case (opc)
            OP_SW:   ImmSrc = 3'b001;
            OP_B:    ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase

        case (state_q)
            S_FETCH: begin
                AluSrcB = 2'b10;
                ResSrc  = 2'b10;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                AluSrcA = 2'b01;
                AluSrcB = 2'b01;
                case (opc)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR_ADR;
                    OP_B:         state_d = S_BRANCH;
                    OP_LUI:       state_d = S_LUI_WB;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_FETCH;
                            done    = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                state_d = (opc == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResSrc  = 2'b01;
                RegW    = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                done   = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                AluSrcA = 2'b10;
                if (f7 == 7'b0100000 && f3 == 3'b000) AluCu = ALU_SUB;
                else if (f7 == 7'b0000000)            AluCu = f3_alu(f3);
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                AluCu   = f3_alu(f3);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegW    = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_JALR_ADR: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                state_d = S_JAL;
            end
            // Target already sits in ALUOut; ALU concurrently forms the link value OldPC+4.
            S_JAL: begin
                AluSrcA = 2'b01;
                AluSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                AluSrcA = 2'b10;
                AluCu   = ALU_SUB;
                done    = 1'b1;
                case (f3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    3'b100:  PCWrite = sign;
                    3'b101:  PCWrite = ~sign | zero;
                    default: PCWrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_LUI_WB: begin
                ResSrc  = 2'b11;
                RegW    = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Reset is async, so strobes must be killed combinationally in the same cycle.
        if (rst) begin
            PCWrite = 1'b0;
            MemW    = 1'b0;
            IRWrite = 1'b0;
            RegW    = 1'b0;
            done    = 1'b0;
            halted  = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected cycle tables built
// from per-opcode recipes, randomized operands/handshakes, plus directed trap/reset scenarios.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero, sign, mem_ready;

    logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, done, halted;
    logic [1:0] ResSrc, AluSrcA, AluSrcB;
    logic [3:0] AluCu;
    logic [2:0] ImmSrc;

    logic       PCWrite2, AdrSrc2, MemW2, IRWrite2, RegW2, done2, halted2;
    logic [1:0] ResSrc2, AluSrcA2, AluSrcB2;
    logic [3:0] AluCu2;
    logic [2:0] ImmSrc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opc(opc), .f3(f3), .f7(f7), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW),
        .IRWrite(IRWrite), .RegW(RegW), .ResSrc(ResSrc), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluCu(AluCu), .ImmSrc(ImmSrc), .done(done), .halted(halted)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opc(opc), .f3(f3), .f7(f7), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemW(MemW2),
        .IRWrite(IRWrite2), .RegW(RegW2), .ResSrc(ResSrc2), .AluSrcA(AluSrcA2),
        .AluSrcB(AluSrcB2), .AluCu(AluCu2), .ImmSrc(ImmSrc2), .done(done2), .halted(halted2)
    );

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, sa, sb;
        logic [3:0] alu;
        logic       dn;
    } exp_t;

    exp_t q[$];
    logic mrq[$];
    int   done_cyc, done_cnt, regw_cyc, irw_cnt;
    logic pcw_at_done;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, LUI = 7'b0110111;

    function automatic exp_t base();
        exp_t e = '0;
        e.alu = 4'b0010;
        return e;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f);
        case (f)
            3'd0: return 4'b0010;
            3'd7: return 4'b0000;
            3'd6: return 4'b0001;
            3'd4: return 4'b0011;
            3'd2: return 4'b0111;
            3'd3: return 4'b1000;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == SW)  return 3'b001;
        if (o == BR)  return 3'b010;
        if (o == JAL) return 3'b011;
        if (o == LUI) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic taken(input logic [2:0] f, input logic z, input logic s);
        case (f)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return s;
            3'd5: return !s || z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input exp_t e, input logic mr);
        q.push_back(e);
        mrq.push_back(mr);
    endfunction

    function automatic void push_wb();
        exp_t e = base();
        e.regw = 1; e.dn = 1;
        push(e, 1'($urandom_range(0, 1)));
    endfunction

    // Expected per-cycle output table for one legal instruction.
    function automatic void build(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                                  input logic z, input logic s, input int fw, input int mw);
        exp_t e;
        q.delete();
        mrq.delete();
        e = base(); e.sb = 2; e.res = 2;
        for (int i = 0; i < fw; i++) push(e, 1'b0);
        e.irw = 1; e.pcw = 1;
        push(e, 1'b1);
        e = base(); e.sa = 1; e.sb = 1;
        push(e, 1'($urandom_range(0, 1)));
        if (o == LW || o == SW) begin
            e = base(); e.sa = 2; e.sb = 1;
            push(e, 1'($urandom_range(0, 1)));
            e = base(); e.adr = 1; e.memw = (o == SW);
            for (int i = 0; i < mw; i++) push(e, 1'b0);
            e.dn = (o == SW);
            push(e, 1'b1);
            if (o == LW) begin
                e = base(); e.res = 1; e.regw = 1; e.dn = 1;
                push(e, 1'($urandom_range(0, 1)));
            end
        end else if (o == RT) begin
            e = base(); e.sa = 2; e.sb = 0;
            if (fn7 == 7'b0100000 && fn3 == 3'd0) e.alu = 4'b0110;
            else if (fn7 == 7'd0)                 e.alu = alu_of(fn3);
            push(e, 1'($urandom_range(0, 1)));
            push_wb();
        end else if (o == IT) begin
            e = base(); e.sa = 2; e.sb = 1; e.alu = alu_of(fn3);
            push(e, 1'($urandom_range(0, 1)));
            push_wb();
        end else if (o == JAL || o == JALR) begin
            if (o == JALR) begin
                e = base(); e.sa = 2; e.sb = 1;
                push(e, 1'($urandom_range(0, 1)));
            end
            e = base(); e.sa = 1; e.sb = 2; e.pcw = 1;
            push(e, 1'($urandom_range(0, 1)));
            push_wb();
        end else if (o == BR) begin
            e = base(); e.sa = 2; e.alu = 4'b0110; e.dn = 1; e.pcw = taken(fn3, z, s);
            push(e, 1'($urandom_range(0, 1)));
        end else begin
            e = base(); e.res = 3; e.regw = 1; e.dn = 1;
            push(e, 1'($urandom_range(0, 1)));
        end
    endfunction

    // Drives one instruction and checks every cycle; stops at the negedge of cycle ncyc if ncyc > 0.
    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] fn3,
                             input logic [6:0] fn7, input logic z, input logic s,
                             input int fw, input int mw, input int ncyc);
        exp_t got, got2;
        build(o, fn3, fn7, z, s, fw, mw);
        opc = o; f3 = fn3; f7 = fn7; zero = z; sign = s;
        done_cyc = 0; done_cnt = 0; regw_cyc = 0; irw_cnt = 0; pcw_at_done = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = mrq[i];
            @(negedge clk);
            got  = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ResSrc, AluSrcA, AluSrcB, AluCu, done};
            got2 = {PCWrite2, AdrSrc2, MemW2, IRWrite2, RegW2, ResSrc2, AluSrcA2, AluSrcB2, AluCu2, done2};
            checks += 3;
            if (got !== q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d outputs: got %h expected %h", nm, i + 1, got, q[i]);
            end
            if (got2 !== q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d nop-variant outputs: got %h expected %h", nm, i + 1, got2, q[i]);
            end
            if (ImmSrc !== imm_of(o) || halted !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d immsrc/halted: got %b/%b expected %b/0", nm, i + 1, ImmSrc, halted, imm_of(o));
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = i + 1; pcw_at_done = PCWrite; end
            if (RegW === 1'b1) regw_cyc = i + 1;
            if (IRWrite === 1'b1) irw_cnt++;
            if (ncyc > 0 && i + 1 == ncyc) return;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opc = RT; f3 = 0; f7 = 0; zero = 0; sign = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({PCWrite, MemW, IRWrite, RegW, done, halted} !== 6'b0) begin
            errors++;
            $display("FAIL reset enables: got %b expected 000000", {PCWrite, MemW, IRWrite, RegW, done, halted});
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_add();
        run_instr("add", RT, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0);
        checks += 2;
        if (done_cyc !== 4) begin errors++; $display("FAIL add length: got %0d expected 4", done_cyc); end
        if (done_cnt !== 1) begin errors++; $display("FAIL add done count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_lw_waits();
        run_instr("lw_wait", LW, 3'd2, 7'd0, 1'b0, 1'b0, 2, 2, 0);
        checks += 3;
        if (regw_cyc !== 9) begin errors++; $display("FAIL lw regw cycle: got %0d expected 9", regw_cyc); end
        if (done_cnt !== 1) begin errors++; $display("FAIL lw done count: got %0d expected 1", done_cnt); end
        if (irw_cnt !== 1)  begin errors++; $display("FAIL lw irwrite count: got %0d expected 1", irw_cnt); end
    endtask

    task automatic test_branch();
        logic [2:0] bf[4]  = '{3'd0, 3'd1, 3'd5, 3'd2};
        logic       bz[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_instr("branch", BR, bf[i], 7'd0, bz[i], 1'b0, 0, 0, 0);
            checks += 2;
            if (pcw_at_done !== exp[i]) begin
                errors++;
                $display("FAIL branch f3=%0d taken: got %b expected %b", bf[i], pcw_at_done, exp[i]);
            end
            if (done_cyc !== 3) begin errors++; $display("FAIL branch length: got %0d expected 3", done_cyc); end
        end
    endtask

    task automatic test_jalr();
        run_instr("jalr", JALR, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 0);
        checks++;
        if (done_cyc !== 5) begin errors++; $display("FAIL jalr length: got %0d expected 5", done_cyc); end
    endtask

    task automatic test_random();
        logic [6:0] ops[8] = '{LW, SW, RT, IT, JAL, JALR, BR, LUI};
        logic [6:0] o, fn7;
        for (int n = 0; n < 80; n++) begin
            o = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 2))
                0: fn7 = 7'd0;
                1: fn7 = 7'b0100000;
                default: fn7 = 7'($urandom);
            endcase
            run_instr("random", o, 3'($urandom), fn7, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
    endtask

    task automatic test_trap();
        opc = 7'b1111111; f3 = 0; f7 = 0; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (IRWrite !== 1'b1 || IRWrite2 !== 1'b1) begin
            errors++; $display("FAIL trap fetch irwrite: got %b/%b expected 1/1", IRWrite, IRWrite2);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done2 !== 1'b1) begin
            errors++; $display("FAIL illegal decode done: got %b/%b expected 0/1", done, done2);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (AluSrcB2 !== 2'b10 || ResSrc2 !== 2'b10 || IRWrite2 !== 1'b1) begin
            errors++; $display("FAIL nop variant back in fetch: got srcb %b res %b irw %b expected 10 10 1", AluSrcB2, ResSrc2, IRWrite2);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (halted !== 1'b1 || {PCWrite, MemW, IRWrite, RegW, done} !== 5'b0) begin
                errors++;
                $display("FAIL trap hold cycle %0d: got halted %b enables %b expected 1 00000", i, halted, {PCWrite, MemW, IRWrite, RegW, done});
            end
            @(posedge clk); #1 mem_ready = 1'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || IRWrite !== 1'b0) begin
            errors++; $display("FAIL trap reset: got halted %b irw %b expected 0 0", halted, IRWrite);
        end
        @(posedge clk); #1 rst = 1'b0;
        run_instr("after_trap", IT, 3'd7, 7'd0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_memwrite();
        run_instr("sw_abort", SW, 3'd2, 7'd0, 1'b0, 1'b0, 0, 3, 4);
        checks++;
        if (MemW !== 1'b1) begin errors++; $display("FAIL memwrite strobe before reset: got %b expected 1", MemW); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (MemW !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL memwrite async abort: got memw %b done %b expected 0 0", MemW, done);
        end
        @(posedge clk); #1 rst = 1'b0;
        run_instr("after_abort", LUI, 3'd0, 7'd0, 1'b0, 1'b0, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_waits();
        test_branch();
        test_jalr();
        test_random();
        test_trap();
        test_reset_memwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
